// File: rtl/pwm_pkg.sv
// Shared types and constants for the pulse-width monitor block.
// State encoding is fixed so that debug captures read the same across builds.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } pwm_state_e;

    localparam int DEFAULT_DEPTH = 4;
    localparam int PTR_W         = $clog2(DEFAULT_DEPTH);

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/pwm_fifo.sv
// First-word-fall-through width FIFO: DEPTH x WIDTH_W, extra-MSB pointers, clr wins over push/pop.
// The head word is presented directly from the register file; reads as zero when empty.
module pwm_fifo
    import pwm_pkg::*;
#(
    parameter int WIDTH_W = 8,
    parameter int DEPTH   = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               push,
    input  logic [WIDTH_W-1:0] wdata,
    input  logic               pop,
    output logic [WIDTH_W-1:0] rdata,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [WIDTH_W-1:0] r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign w_do_pop  = pop  & ~empty & ~clr;
    assign w_do_push = push & ~clr & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/pulse_width_monitor.sv
// Measures high pulses on the delay-line output, counts rising edges while armed,
// and queues completed widths for a valid/ready consumer.
module pulse_width_monitor
    import pwm_pkg::*;
#(
    parameter int WIDTH_W = 8,
    parameter int CNT_W   = 8,
    parameter int DEPTH   = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               din,
    input  logic               clr,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [WIDTH_W-1:0] rd_width,
    output logic [CNT_W-1:0]   edge_cnt,
    output logic               overflow,
    output logic               busy
);

    localparam logic [WIDTH_W-1:0] W_MAX = '1;

    pwm_state_e         r_state;
    logic [WIDTH_W-1:0] r_width;
    logic [CNT_W-1:0]   r_edge_cnt;
    logic               r_overflow;

    pwm_state_e         w_state_next;
    logic [WIDTH_W-1:0] w_width_next;
    logic [CNT_W-1:0]   w_edge_next;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ARM;
            r_width    <= '0;
            r_edge_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_width    <= w_width_next;
            r_edge_cnt <= w_edge_next;
        end
    end

    // Priority: clr, then ena low (abort, nothing pushed), then normal measurement.
    always_comb begin
        w_state_next = r_state;
        w_width_next = r_width;
        w_edge_next  = r_edge_cnt;
        w_push       = 1'b0;
        if (clr) begin
            w_state_next = ST_ARM;
            w_width_next = '0;
            w_edge_next  = '0;
        end else if (!ena) begin
            w_state_next = ST_ARM;
            w_width_next = '0;
        end else begin
            unique case (r_state)
                ST_ARM: begin
                    // Wait for a low so a pulse already in flight at arm time is ignored.
                    if (!din) begin
                        w_state_next = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (din) begin
                        w_state_next = ST_HIGH;
                        w_width_next = WIDTH_W'(1);
                        w_edge_next  = r_edge_cnt + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (din) begin
                        if (r_width != W_MAX) begin
                            w_width_next = r_width + WIDTH_W'(1);
                        end
                    end else begin
                        w_push       = 1'b1;
                        w_state_next = ST_LOW;
                    end
                end
                default: begin
                    w_state_next = ST_ARM;
                    w_width_next = '0;
                end
            endcase
        end
    end

    assign w_pop = ~w_empty & rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    pwm_fifo #(
        .WIDTH_W (WIDTH_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (w_push),
        .wdata (r_width),
        .pop   (w_pop),
        .rdata (rd_width),
        .full  (w_full),
        .empty (w_empty)
    );

    assign rd_valid = ~w_empty;
    assign edge_cnt = r_edge_cnt;
    assign overflow = r_overflow;
    assign busy     = (r_state == ST_HIGH);

endmodule

// File: tb/tb_pulse_width_monitor.sv
// Directed bench for pulse_width_monitor with a width scoreboard and a small status model.
module tb_pulse_width_monitor;
    import pwm_pkg::*;

    localparam int WIDTH_W = 8;
    localparam int CNT_W   = 8;
    localparam int DEPTH   = 4;
    localparam int W_MAX   = (1 << WIDTH_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ena;
    logic               din;
    logic               clr;
    logic               rd_ready;
    logic               rd_valid;
    logic [WIDTH_W-1:0] rd_width;
    logic [CNT_W-1:0]   edge_cnt;
    logic               overflow;
    logic               busy;

    int checks    = 0;
    int failures  = 0;
    int sb[$];
    int exp_edges = 0;
    int exp_ovf   = 0;

    always #5 clk = ~clk;

    pulse_width_monitor #(
        .WIDTH_W (WIDTH_W),
        .CNT_W   (CNT_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .din      (din),
        .clr      (clr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_width (rd_width),
        .edge_cnt (edge_cnt),
        .overflow (overflow),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_edge_cnt"}, 32'(edge_cnt), 32'(exp_edges));
        check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'(sb.size() != 0));
        $display("status %s edge_cnt=%0d overflow=%0d rd_valid=%0d", tag, edge_cnt, overflow, rd_valid);
    endtask

    // Drive a pulse of w high samples from state LOW; optionally pop on the falling-edge cycle.
    task automatic pulse(input int w, input bit pop_at_fall, input string tag);
        din = 1'b1;
        repeat (w) tick();
        exp_edges = (exp_edges + 1) % (1 << CNT_W);
        din = 1'b0;
        if (pop_at_fall) begin
            check({tag, "_head_at_fall"}, 32'(rd_width), 32'(sb[0]));
            rd_ready = 1'b1;
        end
        tick();
        rd_ready = 1'b0;
        if (pop_at_fall) void'(sb.pop_front());
        if (sb.size() < DEPTH) sb.push_back((w > W_MAX) ? W_MAX : w);
        else exp_ovf = 1;
        $display("pulse %s width=%0d pop=%0d queued=%0d", tag, w, pop_at_fall, sb.size());
    endtask

    task automatic read_entry(input string tag);
        int exp_w;
        exp_w = (sb.size() != 0) ? sb.pop_front() : 0;
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_rd_width"}, 32'(rd_width), 32'(exp_w));
        $display("read %s rd_width=%0d expected=%0d", tag, rd_width, exp_w);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic do_clr();
        din = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        sb.delete();
        exp_edges = 0;
        exp_ovf   = 0;
        $display("clear issued");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        din      = 1'b1;
        clr      = 1'b0;
        rd_ready = 1'b0;
        repeat (2) tick();
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_width", 32'(rd_width), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // 1: high already present at arm is never measured
        rst_n = 1'b1;
        repeat (20) tick();
        check("t1_busy",  32'(busy), 32'd0);
        check("t1_state_arm", 32'(dut.r_state), 32'(ST_ARM));
        check_status("t1_high");
        din = 1'b0;
        tick();
        check("t1_state_low", 32'(dut.r_state), 32'(ST_LOW));
        check_status("t1_low");

        // 2: five-cycle pulse then a single pop
        pulse(5, 1'b0, "t2");
        check_status("t2");
        read_entry("t2_rd");
        check_status("t2_after_pop");

        // 3: saturating width
        do_clr();
        pulse(300, 1'b0, "t3");
        check_status("t3");
        read_entry("t3_rd");

        // 4: FIFO fills, later widths dropped
        do_clr();
        for (int i = 1; i <= 6; i++) pulse(i, 1'b0, "t4");
        check_status("t4_full");
        for (int i = 0; i < 4; i++) read_entry("t4_rd");
        check("t4_empty_valid", 32'(rd_valid), 32'd0);
        check("t4_empty_width", 32'(rd_width), 32'd0);

        // 5: push and pop together while full
        do_clr();
        for (int i = 1; i <= 4; i++) pulse(i, 1'b0, "t5_fill");
        pulse(7, 1'b1, "t5_fall_pop");
        check_status("t5");
        for (int i = 0; i < 4; i++) read_entry("t5_rd");
        check_status("t5_drained");

        // 6: ena low aborts a pulse, clr wipes state
        do_clr();
        for (int i = 1; i <= 5; i++) pulse(i, 1'b0, "t6_fill");
        din = 1'b1;
        repeat (3) tick();
        exp_edges = exp_edges + 1;
        check("t6_busy_mid", 32'(busy), 32'd1);
        ena = 1'b0;
        tick();
        check("t6_busy_abort", 32'(busy), 32'd0);
        din = 1'b0;
        tick();
        ena = 1'b1;
        tick();
        check_status("t6_after_abort");
        check("t6_head", 32'(rd_width), 32'(sb[0]));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        sb.delete();
        exp_edges = 0;
        exp_ovf   = 0;
        check_status("t6_after_clr");
        check("t6_clr_width", 32'(rd_width), 32'd0);

        // 6b: asynchronous reset in the middle of a pulse
        tick();
        pulse(3, 1'b0, "t6b");
        din = 1'b1;
        repeat (2) tick();
        check("t6b_busy_mid", 32'(busy), 32'd1);
        check("t6b_valid_mid", 32'(rd_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6b_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("t6b_rst_rd_width", 32'(rd_width), 32'd0);
        check("t6b_rst_busy",     32'(busy),     32'd0);
        check("t6b_rst_edge_cnt", 32'(edge_cnt), 32'd0);
        check("t6b_rst_overflow", 32'(overflow), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
